// File: rtl/two_req_arb_pkg.sv
// Shared types and constants for the two-request round-robin arbiter.
package two_req_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HOLD = 2'b01,
      ACK  = 2'b10
   } state_t;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/two_req_arbiter_rr_pick.sv
// Combinational round-robin pick between two requesters.
module rr_pick
   import two_req_arb_pkg::*;
(
   input  logic a_req,
   input  logic b_req,
   input  logic last_src,
   output logic win,
   output logic win_src
);

   always_comb begin
      win     = a_req | b_req;
      win_src = SRC_A;
      // On a tie the source that did not win last time goes first
      if (a_req && b_req) begin
         win_src = ~last_src;
      end else if (b_req) begin
         win_src = SRC_B;
      end
   end

endmodule

// File: rtl/two_req_arbiter.sv
// Two-request round-robin arbiter with valid/ready output and grant pulse.
// Optional grant counter built when ARB_GRANT_CNT_EN is defined.
module two_req_arbiter
   import two_req_arb_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_req,
   input  logic             b_req,
   output logic             a_gnt,
   output logic             b_gnt,
   output logic             any_req,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_src,
   output logic [CNT_W-1:0] grant_cnt
);

   state_t state;
   state_t state_d;
   logic   last_src;
   logic   last_src_d;
   logic   src_d;
   logic   valid_d;
   logic   a_gnt_d;
   logic   b_gnt_d;
   logic   win;
   logic   win_src;

   rr_pick u_rr_pick (
      .a_req    (a_req),
      .b_req    (b_req),
      .last_src (last_src),
      .win      (win),
      .win_src  (win_src)
   );

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last_src  <= SRC_B;
         out_src   <= SRC_A;
         out_valid <= 1'b0;
         a_gnt     <= 1'b0;
         b_gnt     <= 1'b0;
         any_req   <= 1'b0;
      end else begin
         state     <= state_d;
         last_src  <= last_src_d;
         out_src   <= src_d;
         out_valid <= valid_d;
         a_gnt     <= a_gnt_d;
         b_gnt     <= b_gnt_d;
         any_req   <= a_req | b_req;
      end
   end

   // Next state and next output values
   always_comb begin
      state_d    = state;
      last_src_d = last_src;
      src_d      = out_src;
      valid_d    = 1'b0;
      a_gnt_d    = 1'b0;
      b_gnt_d    = 1'b0;
      case (state)
         IDLE: begin
            if (win) begin
               state_d = HOLD;
               src_d   = win_src;
               valid_d = 1'b1;
            end
         end
         HOLD: begin
            // out_valid is high throughout HOLD, so out_ready alone completes it
            if (out_ready) begin
               state_d    = ACK;
               last_src_d = out_src;
               a_gnt_d    = (out_src == SRC_A);
               b_gnt_d    = (out_src == SRC_B);
            end else begin
               valid_d = 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef ARB_GRANT_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (state == ACK) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign grant_cnt = cnt_q;
`else
   assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_two_req_arbiter.sv
// Self-checking bench for two_req_arbiter: transaction-level model plus directed checks.
module tb_two_req_arbiter;

   localparam int unsigned CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             a_req;
   logic             b_req;
   logic             a_gnt;
   logic             b_gnt;
   logic             any_req;
   logic             out_valid;
   logic             out_ready;
   logic             out_src;
   logic [CNT_W-1:0] grant_cnt;

   int tests = 0;
   int fails = 0;
   logic chk_en = 1'b0;

   two_req_arbiter #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_req     (a_req),
      .b_req     (b_req),
      .a_gnt     (a_gnt),
      .b_gnt     (b_gnt),
      .any_req   (any_req),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_src   (out_src),
      .grant_cnt (grant_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
      end
   endtask

   // Transaction-level model: a pending winner waits for acceptance, then one grant cycle follows
   logic m_valid, m_src, m_agnt, m_bgnt, m_any, m_last;
   int   m_grants;

   always @(posedge clk) begin
      logic accept, in_grant;
      if (rst) begin
         m_valid = 1'b0; m_src = 1'b0; m_agnt = 1'b0; m_bgnt = 1'b0;
         m_any = 1'b0; m_last = 1'b1; m_grants = 0;
      end else begin
         accept   = m_valid && out_ready;
         in_grant = m_agnt || m_bgnt;
         m_any    = a_req | b_req;
         if (in_grant) m_grants = m_grants + 1;
         m_agnt = accept && !m_src;
         m_bgnt = accept && m_src;
         if (accept) begin
            m_last  = m_src;
            m_valid = 1'b0;
         end else if (!m_valid && !in_grant && (a_req || b_req)) begin
            m_valid = 1'b1;
            m_src   = (a_req && b_req) ? !m_last : b_req;
         end
      end
   end

   function automatic logic [31:0] exp_cnt(input int grants);
`ifdef ARB_GRANT_CNT_EN
      return 32'(grants % (1 << CNT_W));
`else
      return 32'(grants * 0);
`endif
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_any_req",   32'(any_req),   32'(m_any));
         chk("model_out_valid", 32'(out_valid), 32'(m_valid));
         chk("model_a_gnt",     32'(a_gnt),     32'(m_agnt));
         chk("model_b_gnt",     32'(b_gnt),     32'(m_bgnt));
         chk("model_grant_cnt", 32'(grant_cnt), exp_cnt(m_grants));
         if (m_valid) chk("model_out_src", 32'(out_src), 32'(m_src));
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   // One A-only transaction with a bounded wait for its grant
   task automatic single_a(input int idx, input logic [31:0] cnt_exp);
      bit seen = 1'b0;
      a_req = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 10 && !seen; i++) begin
         cyc();
         if (a_gnt) begin
            seen  = 1'b1;
            a_req = 1'b0;
         end
      end
      chk($sformatf("wrap_gnt_seen_%0d", idx), 32'(seen), 32'd1);
      cyc();
      chk($sformatf("wrap_cnt_%0d", idx), 32'(grant_cnt), cnt_exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int        gcyc[$];
      logic      gsrc[$];
      int        bcount, acount;
      int        wrap_exp [5];
      wrap_exp = '{1, 2, 3, 0, 1};

      rst = 1'b1; a_req = 1'b0; b_req = 1'b0; out_ready = 1'b0;
      do_reset();
      chk_en = 1'b1;

      // Reset state
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_a_gnt",     32'(a_gnt),     32'd0);
      chk("rst_b_gnt",     32'(b_gnt),     32'd0);
      chk("rst_any_req",   32'(any_req),   32'd0);
      chk("rst_out_src",   32'(out_src),   32'd0);
      chk("rst_grant_cnt", 32'(grant_cnt), 32'd0);

      // Single request with out_ready already high
      a_req = 1'b1; out_ready = 1'b1;
      cyc();
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_src",   32'(out_src),   32'd0);
      cyc();
      chk("single_a_gnt", 32'(a_gnt), 32'd1);
      a_req = 1'b0;
      cyc();
      chk("single_gnt_drop", 32'(a_gnt), 32'd0);
      chk("single_cnt", 32'(grant_cnt), exp_cnt(1));
      cyc();

      // Tie fairness from reset: A, B, A, B at 3-cycle spacing
      do_reset();
      a_req = 1'b1; b_req = 1'b1; out_ready = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         if (a_gnt || b_gnt) begin
            gcyc.push_back(i);
            gsrc.push_back(b_gnt);
         end
         a_req = !a_gnt;
         b_req = !b_gnt;
      end
      a_req = 1'b0; b_req = 1'b0;
      chk("tie_grant_count", 32'(gcyc.size()), 32'd4);
      for (int k = 0; k < 4 && k < gcyc.size(); k++) begin
         chk($sformatf("tie_cycle_%0d", k), 32'(gcyc[k]), 32'(2 + 3 * k));
         chk($sformatf("tie_src_%0d", k),   32'(gsrc[k]), 32'(k % 2));
      end
      cyc(); cyc(); cyc();

      // Backpressure: held stable for 5 cycles, grant one cycle after ready rises
      a_req = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
         chk($sformatf("bp_src_%0d", i),   32'(out_src),   32'd0);
      end
      out_ready = 1'b1;
      cyc();
      chk("bp_a_gnt", 32'(a_gnt), 32'd1);
      a_req = 1'b0;
      cyc(); cyc();

      // Withdrawal: one-cycle b_req still completes with one b_gnt
      out_ready = 1'b0; b_req = 1'b1;
      cyc();
      b_req = 1'b0;
      chk("wd_valid", 32'(out_valid), 32'd1);
      chk("wd_src",   32'(out_src),   32'd1);
      bcount = 0; acount = 0;
      for (int i = 0; i < 7; i++) begin
         if (i == 2) out_ready = 1'b1;
         cyc();
         bcount += int'(b_gnt);
         acount += int'(a_gnt);
      end
      chk("wd_b_gnt_once", 32'(bcount), 32'd1);
      chk("wd_no_a_gnt",   32'(acount), 32'd0);

      // Reset during HOLD: everything cleared, no grant, A wins the next tie
      a_req = 1'b1; out_ready = 1'b0;
      cyc();
      chk("mr_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      cyc();
      chk("mr_valid0",  32'(out_valid), 32'd0);
      chk("mr_a_gnt0",  32'(a_gnt),     32'd0);
      chk("mr_b_gnt0",  32'(b_gnt),     32'd0);
      chk("mr_any0",    32'(any_req),   32'd0);
      chk("mr_src0",    32'(out_src),   32'd0);
      chk("mr_cnt0",    32'(grant_cnt), 32'd0);
      rst = 1'b0; b_req = 1'b1; out_ready = 1'b1;
      cyc();
      chk("mr_tie_valid", 32'(out_valid), 32'd1);
      chk("mr_tie_src",   32'(out_src),   32'd0);
      cyc();
      chk("mr_tie_a_gnt", 32'(a_gnt), 32'd1);
      a_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (b_gnt) b_req = 1'b0;
      end
      b_req = 1'b0;
      cyc();

      // Counter wrap
      do_reset();
      for (int g = 0; g < 5; g++) begin
`ifdef ARB_GRANT_CNT_EN
         single_a(g, 32'(wrap_exp[g]));
`else
         single_a(g, 32'(wrap_exp[g] * 0));
`endif
      end
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
